sample_pacer: RTL and testbench



---
 rtl/pacer_pkg.sv | 24 ++
 rtl/sample_fifo.sv | 68 ++++++
 rtl/sample_pacer.sv | 126 ++++++++++++
 tb/tb_sample_pacer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pacer_pkg.sv
// Shared types and constants for the sample pacer.
// Holds the FSM encoding, default sizes and a clog2 helper.
package pacer_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int DEF_DATA_W   = 8;
    localparam int DEF_DEPTH    = 4;
    localparam int DEF_PERIOD_W = 8;

    // Smallest r with 2**r >= v (0 for v <= 1)
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Small synchronous FIFO with a combinational head output.
// Pointers carry one extra wrap bit to tell full from empty.
module sample_fifo
    import pacer_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic                    pop,
    input  logic [DATA_W-1:0]       din,
    output logic [DATA_W-1:0]       dout,
    output logic [clog2(DEPTH):0]   count
);

    localparam int AW = clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW:0]       wr_ptr_q;
    logic [AW:0]       wr_ptr_d;
    logic [AW:0]       rd_ptr_q;
    logic [AW:0]       rd_ptr_d;
    logic              full;
    logic              empty;
    logic              push_ok;
    logic              pop_ok;

    assign count   = wr_ptr_q - rd_ptr_q;
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW])
                  && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q[AW-1:0]];

    // Advance pointers on accepted push/pop
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // Pointer registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/sample_pacer.sv
// Replays buffered samples to the filter as paced strobes.
// Each strobe drives a new value on data for one flagged cycle.
module sample_pacer
    import pacer_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int PERIOD_W = DEF_PERIOD_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic                  enable,
    input  logic [PERIOD_W-1:0]   period,
    input  logic                  clear_underrun,
    output logic [DATA_W-1:0]     data,
    output logic                  input_data_flag,
    output logic [clog2(DEPTH):0] fifo_count,
    output logic                  underrun
);

    localparam int CW = clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [PERIOD_W-1:0] ONE_P = PERIOD_W'(1);

    state_e              state_q;
    state_e              state_d;
    logic [PERIOD_W-1:0] cnt_q;
    logic [PERIOD_W-1:0] cnt_d;
    logic [DATA_W-1:0]   data_q;
    logic [DATA_W-1:0]   data_d;
    logic                flag_q;
    logic                flag_d;
    logic                underrun_q;
    logic                underrun_d;

    logic [CW-1:0]       count;
    logic [DATA_W-1:0]   head;
    logic                push;
    logic                pop;
    logic                have_data;
    logic [PERIOD_W-1:0] period_eff;
    logic [PERIOD_W-1:0] reload;

    assign s_ready    = (count < DEPTH_C);
    assign push       = s_valid && s_ready;
    assign have_data  = (count != '0);
    assign period_eff = (period == '0) ? ONE_P : period;
    assign reload     = period_eff - ONE_P;

    sample_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (push),
        .pop    (pop),
        .din    (s_data),
        .dout   (head),
        .count  (count)
    );

    // Pacing FSM: pop on each slot, count down between slots
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        flag_d     = 1'b0;
        underrun_d = underrun_q && !clear_underrun;
        pop        = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (enable && have_data) begin
                    pop     = 1'b1;
                    data_d  = head;
                    flag_d  = 1'b1;
                    cnt_d   = reload;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - ONE_P;
                end else if (have_data) begin
                    pop    = 1'b1;
                    data_d = head;
                    flag_d = 1'b1;
                    cnt_d  = reload;
                end else begin
                    underrun_d = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
        endcase
    end

    // State, counter and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            data_q     <= '0;
            flag_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            flag_q     <= flag_d;
            underrun_q <= underrun_d;
        end
    end

    assign data            = data_q;
    assign input_data_flag = flag_q;
    assign underrun        = underrun_q;
    assign fifo_count      = count;

endmodule

// File: tb/tb_sample_pacer.sv
// Directed bench for sample_pacer with hand-computed expectations.
// Strobe times are logged per cycle and checked after each scenario.
module tb_sample_pacer;

    logic       clk;
    logic       rst;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic       enable;
    logic [7:0] period;
    logic       clear_underrun;
    logic [7:0] data;
    logic       input_data_flag;
    logic [2:0] fifo_count;
    logic       underrun;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int ur_cyc = -1;
    int stb_cyc[$];
    int stb_dat[$];
    int fc_log[64];

    sample_pacer #(
        .DATA_W   (8),
        .DEPTH    (4),
        .PERIOD_W (8)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .s_data          (s_data),
        .s_valid         (s_valid),
        .s_ready         (s_ready),
        .enable          (enable),
        .period          (period),
        .clear_underrun  (clear_underrun),
        .data            (data),
        .input_data_flag (input_data_flag),
        .fifo_count      (fifo_count),
        .underrun        (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (input_data_flag) begin
            stb_cyc.push_back(cyc);
            stb_dat.push_back(int'(data));
        end
        if (underrun && ur_cyc < 0) ur_cyc = cyc;
        if (cyc < 64) fc_log[cyc] = int'(fifo_count);
    endtask

    task automatic clear_log();
        cyc = 0;
        ur_cyc = -1;
        stb_cyc.delete();
        stb_dat.delete();
        for (int i = 0; i < 64; i++) fc_log[i] = -1;
    endtask

    task automatic push_one(input int v);
        s_data  = 8'(v);
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
    endtask

    task automatic clr_ur();
        clear_underrun = 1'b1;
        tick();
        clear_underrun = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        s_data = '0;
        s_valid = 1'b0;
        enable = 1'b0;
        period = '0;
        clear_underrun = 1'b0;
        #2;
        chk("rst_data", int'(data), 0);
        chk("rst_flag", int'(input_data_flag), 0);
        chk("rst_ur", int'(underrun), 0);
        chk("rst_fc", int'(fifo_count), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_ready", int'(s_ready), 1);

        // Single sample, period 10
        enable = 1'b1;
        period = 8'd10;
        clear_log();
        push_one(17);
        chk("t1_fc", int'(fifo_count), 1);
        chk("t1_flag0", int'(input_data_flag), 0);
        tick();
        chk("t1_flag", int'(input_data_flag), 1);
        chk("t1_data", int'(data), 17);
        chk("t1_fc0", int'(fifo_count), 0);
        for (int i = 0; i < 9; i++) begin
            tick();
            chk("t1_gap_flag", int'(input_data_flag), 0);
            chk("t1_hold", int'(data), 17);
        end
        tick();
        chk("t1_ur", int'(underrun), 1);
        clr_ur();
        chk("t1_ur_clr", int'(underrun), 0);

        // Three samples, period 10
        clear_log();
        push_one(17);
        s_valid = 1'b1;
        s_data = 8'd18;
        tick();
        s_data = 8'd19;
        tick();
        s_valid = 1'b0;
        repeat (32) tick();
        chk("t2_nstb", stb_cyc.size(), 3);
        if (stb_cyc.size() == 3) begin
            chk("t2_c0", stb_cyc[0], 2);
            chk("t2_c1", stb_cyc[1], 12);
            chk("t2_c2", stb_cyc[2], 22);
            chk("t2_d0", stb_dat[0], 17);
            chk("t2_d1", stb_dat[1], 18);
            chk("t2_d2", stb_dat[2], 19);
        end
        chk("t2_fc3", fc_log[3], 2);
        chk("t2_fc12", fc_log[12], 1);
        chk("t2_fc22", fc_log[22], 0);
        chk("t2_urcyc", ur_cyc, 32);

        // Fill while disabled, then period 0
        enable = 1'b0;
        clr_ur();
        period = 8'd0;
        for (int i = 0; i < 4; i++) push_one(8'hA0 + i);
        chk("t3_ready", int'(s_ready), 0);
        chk("t3_fc", int'(fifo_count), 4);
        chk("t3_ur", int'(underrun), 0);
        push_one(8'hA4);
        chk("t3_fc_full", int'(fifo_count), 4);
        clear_log();
        enable = 1'b1;
        repeat (6) tick();
        chk("t3_nstb", stb_cyc.size(), 4);
        if (stb_cyc.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("t3_cyc", stb_cyc[i], i + 1);
                chk("t3_dat", stb_dat[i], 8'hA0 + i);
            end
        end
        chk("t3_urcyc", ur_cyc, 5);

        // Pause mid-run with two queued
        enable = 1'b0;
        clr_ur();
        period = 8'd4;
        for (int i = 0; i < 4; i++) push_one(8'hB0 + i);
        clear_log();
        enable = 1'b1;
        repeat (5) tick();
        chk("t4_nstb_a", stb_cyc.size(), 2);
        if (stb_cyc.size() == 2) begin
            chk("t4_c0", stb_cyc[0], 1);
            chk("t4_c1", stb_cyc[1], 5);
            chk("t4_d0", stb_dat[0], 8'hB0);
            chk("t4_d1", stb_dat[1], 8'hB1);
        end
        chk("t4_fc_a", int'(fifo_count), 2);
        enable = 1'b0;
        repeat (5) tick();
        chk("t4_nstb_b", stb_cyc.size(), 2);
        chk("t4_fc_b", int'(fifo_count), 2);
        enable = 1'b1;
        repeat (5) tick();
        chk("t4_nstb_c", stb_cyc.size(), 4);
        if (stb_cyc.size() == 4) begin
            chk("t4_c2", stb_cyc[2], 11);
            chk("t4_c3", stb_cyc[3], 15);
            chk("t4_d2", stb_dat[2], 8'hB2);
            chk("t4_d3", stb_dat[3], 8'hB3);
        end

        // Underrun set beats clear
        repeat (4) tick();
        chk("t5_ur_cyc", ur_cyc, 19);
        chk("t5_ur", int'(underrun), 1);
        period = 8'd1;
        push_one(8'hC5);
        tick();
        chk("t5_flag", int'(input_data_flag), 1);
        chk("t5_data", int'(data), 8'hC5);
        clear_underrun = 1'b1;
        tick();
        chk("t5_set_wins", int'(underrun), 1);
        chk("t5_flag0", int'(input_data_flag), 0);
        tick();
        clear_underrun = 1'b0;
        chk("t5_cleared", int'(underrun), 0);

        // Async reset mid-run
        enable = 1'b0;
        period = 8'd10;
        for (int i = 0; i < 4; i++) push_one(8'hE0 + i);
        enable = 1'b1;
        tick();
        chk("t6_flag", int'(input_data_flag), 1);
        chk("t6_data", int'(data), 8'hE0);
        chk("t6_fc", int'(fifo_count), 3);
        clr_ur();
        tick();
        #3;
        rst = 1'b1;
        #1;
        chk("t6_rst_data", int'(data), 0);
        chk("t6_rst_flag", int'(input_data_flag), 0);
        chk("t6_rst_fc", int'(fifo_count), 0);
        chk("t6_rst_ready", int'(s_ready), 1);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("t6_post_fc", int'(fifo_count), 0);
        chk("t6_post_flag", int'(input_data_flag), 0);
        chk("t6_post_data", int'(data), 0);
        chk("t6_post_ur", int'(underrun), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
